seven_segment_scanner: RTL and testbench

//  Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits sharing one segment bus.

---
 rtl/seven_segment_scanner.sv | 115 +++++++++++
 tb/tb_seven_segment_scanner.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed hex driver for NUM_DIGITS common-anode seven-segment digits on one segment bus.
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading zero digits of the committed frame.
module seven_segment_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 16,
    parameter bit ANODE_ACT   = 1'b0
) (
    input  logic                    clock_in,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   digit_enable,
    output logic [0:6]              segment,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_start
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [0:6] SEG_OFF = 7'h7F;

    logic [PW-1:0]           prescaler;
    logic [IW-1:0]           digit_idx;
    logic                    blank_phase;
    logic [4*NUM_DIGITS-1:0] pending;
    logic [4*NUM_DIGITS-1:0] display;

    logic                    tick;
    logic                    last_digit;
    logic                    commit;
    logic [3:0]              cur_nibble;
    logic                    cur_enable;
    logic                    lz_blank;
    logic                    show;
    logic [0:6]              segment_next;
    logic [NUM_DIGITS-1:0]   anode_next;

    // Segment patterns are {A..G}, active-low.
    function automatic logic [0:6] hex_decode(input logic [3:0] nib);
        case (nib)
            4'h0: hex_decode = 7'h01;
            4'h1: hex_decode = 7'h4F;
            4'h2: hex_decode = 7'h12;
            4'h3: hex_decode = 7'h06;
            4'h4: hex_decode = 7'h4C;
            4'h5: hex_decode = 7'h24;
            4'h6: hex_decode = 7'h20;
            4'h7: hex_decode = 7'h0F;
            4'h8: hex_decode = 7'h00;
            4'h9: hex_decode = 7'h04;
            4'hA: hex_decode = 7'h08;
            4'hB: hex_decode = 7'h60;
            4'hC: hex_decode = 7'h31;
            4'hD: hex_decode = 7'h42;
            4'hE: hex_decode = 7'h30;
            4'hF: hex_decode = 7'h38;
        endcase
    endfunction

    assign tick       = (prescaler == PW'(REFRESH_DIV - 1));
    assign last_digit = (digit_idx == IW'(NUM_DIGITS - 1));
    assign commit     = tick && last_digit;

    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    always_comb begin
        cur_nibble = 4'h0;
        cur_enable = 1'b0;
        lz_blank   = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_idx == IW'(k)) begin
                cur_nibble = display[4*k +: 4];
                cur_enable = digit_enable[k];
`ifdef LEADING_ZERO_BLANK_EN
                lz_blank   = (k != 0) && ((display >> (4*k)) == '0);
`endif
            end
        end
        show         = !blank_phase && cur_enable && !lz_blank;
        segment_next = show ? hex_decode(cur_nibble) : SEG_OFF;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            anode_next[k] = (show && digit_idx == IW'(k)) ? ANODE_ACT : ~ANODE_ACT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            prescaler   <= '0;
            digit_idx   <= '0;
            blank_phase <= 1'b1;
            pending     <= '0;
            display     <= '0;
            segment     <= SEG_OFF;
            anode       <= {NUM_DIGITS{~ANODE_ACT}};
            frame_start <= 1'b0;
        end else begin
            prescaler   <= tick ? '0 : prescaler + PW'(1);
            blank_phase <= tick;
            if (tick) begin
                digit_idx <= last_digit ? '0 : digit_idx + IW'(1);
            end
            if (load) begin
                pending <= value;
            end
            // A load on the commit edge bypasses straight to the display.
            if (commit) begin
                display <= load ? value : pending;
            end
            segment     <= segment_next;
            anode       <= anode_next;
            frame_start <= commit;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Randomized bench for seven_segment_scanner against a cycle-count based frame model.
// Honors LEADING_ZERO_BLANK_EN when it is defined for the build.
module tb_seven_segment_scanner;

    localparam int N = 4;
    localparam int R = 4;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB_ON = 1'b1;
`else
    localparam bit LZB_ON = 1'b0;
`endif

    logic          clock_in = 1'b0;
    logic          reset;
    logic [4*N-1:0] value;
    logic          load;
    logic [N-1:0]  digit_enable;
    logic [0:6]    segment;
    logic [N-1:0]  anode;
    logic          frame_start;

    seven_segment_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(R), .ANODE_ACT(1'b0)) dut (
        .clock_in    (clock_in),
        .reset       (reset),
        .value       (value),
        .load        (load),
        .digit_enable(digit_enable),
        .segment     (segment),
        .anode       (anode),
        .frame_start (frame_start)
    );

    always #5 clock_in = ~clock_in;

    // Decode table from the datasheet, {A..G} active-low.
    logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    // Model: t counts cycles since reset release; slot and digit follow from plain division.
    int             t;
    logic [4*N-1:0] m_pending;
    logic [4*N-1:0] m_display;
    int             cyc;
    int             last_fs;
    int             n_checks = 0;
    int             n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, obs, exp, t, $time);
        end
    endtask

    function automatic bit lead_zero(input int idx, input logic [4*N-1:0] d);
        return LZB_ON && idx > 0 && ((d >> (4*idx)) == 0);
    endfunction

    task automatic step();
        int         pos, idx, nib;
        bit         commit, lit;
        logic [6:0] exp_seg;
        logic [N-1:0] exp_an;
        pos     = t % R;
        idx     = (t / R) % N;
        commit  = (pos == R-1) && (idx == N-1);
        nib     = int'((m_display >> (4*idx)) & 16'hF);
        lit     = (pos != 0) && digit_enable[idx] && !lead_zero(idx, m_display);
        exp_seg = lit ? seg_tab[nib] : 7'h7F;
        exp_an  = lit ? ~(N'(1) << idx) : {N{1'b1}};
        @(posedge clock_in);
        #1;
        cyc++;
        check("segment", 32'(segment), 32'(exp_seg));
        check("anode", 32'(anode), 32'(exp_an));
        check("frame_start", 32'(frame_start), 32'(commit));
        if (frame_start === 1'b1) begin
            if (last_fs >= 0) check("frame_gap", 32'(cyc - last_fs), 32'(N*R));
            last_fs = cyc;
        end
        if (commit) m_display = load ? value : m_pending;
        if (load) m_pending = value;
        t++;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic load_value(input logic [4*N-1:0] v);
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    // Called right after a step; asserts reset between edges and checks the asynchronous clear.
    task automatic apply_reset(input int hold);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_seg", 32'(segment), 32'h7F);
        check("rst_async_anode", 32'(anode), 32'(N'('1)));
        check("rst_async_fs", 32'(frame_start), 32'h0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock_in);
            #1;
            check("rst_seg", 32'(segment), 32'h7F);
            check("rst_anode", 32'(anode), 32'(N'('1)));
            check("rst_fs", 32'(frame_start), 32'h0);
        end
        reset     = 1'b0;
        t         = 0;
        m_pending = '0;
        m_display = '0;
        last_fs   = -1;
    endtask

    task automatic step_until_digit(input int idx);
        for (int i = 0; i < N*R && ((t / R) % N != idx || t % R != 0); i++) step();
    endtask

    initial begin
        reset        = 1'b1;
        load         = 1'b0;
        value        = '0;
        digit_enable = '1;
        t            = 0;
        cyc          = 0;
        last_fs      = -1;
        m_pending    = '0;
        m_display    = '0;

        // Power-on reset, then release.
        apply_reset(10);

        // Basic frame: value only appears after the next commit.
        load_value(16'h3A91);
        run(2*N*R);

        // Mid-frame load at digit 1 must not tear the current frame.
        step_until_digit(1);
        load_value(16'h1234);
        run(3*N*R);

        // Per-digit enable with identical nibbles.
        digit_enable = 4'b0101;
        load_value(16'h8888);
        run(2*N*R);
        digit_enable = 4'b1111;

        // Load coinciding with the commit tick bypasses to the display.
        load_value(16'h5555);
        for (int i = 0; i < N*R && (t % (N*R)) != N*R-1; i++) step();
        load_value(16'hC0DE);
        run(N*R + 5);

        // Mid-slot reset, then scanning restarts at digit 0.
        apply_reset(3);
        run(N*R);

        // Leading-zero cases (shown in full when the option is off).
        load_value(16'h0050);
        run(2*N*R);
        load_value(16'h0000);
        run(2*N*R);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if (i % 23 == 0) digit_enable = N'($urandom);
            value = 16'($urandom);
            if ($urandom_range(0, 7) == 0) value = value & 16'h00FF;
            load  = ($urandom_range(0, 7) == 0);
            step();
            load  = 1'b0;
            if ($urandom_range(0, 499) == 0) apply_reset($urandom_range(1, 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
